// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: datapath widths,
// the PC increment, and the layout of one buffered fetch entry.
package inst_prefetch_buffer_pkg;

    localparam int ADDR_LEN  = 32;
    localparam int INSTR_LEN = 32;
    localparam logic [ADDR_LEN-1:0] PC_INC = 32'd4;

    // One FIFO entry: returned instruction plus its fetch address + 4
    typedef struct packed {
        logic [INSTR_LEN-1:0] inst;
        logic [ADDR_LEN-1:0]  pc_plus_4;
    } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// prefetch_fifo: synchronous FIFO for fetched instructions. clear has
// priority over push/pop; DEPTH must be a power of two so the pointers
// wrap naturally.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy update; a redirect clear wins over everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential instruction fetch into a small FIFO
// feeding decode. Issue is credit-limited (count + inflight < DEPTH) so the
// FIFO never overflows; a redirect flushes buffered and in-flight work.
// Optional feature: INST_PREFETCH_BYPASS_EN forwards a response straight to
// out_* when the FIFO is empty.
module inst_prefetch_buffer
    import inst_prefetch_buffer_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [ADDR_LEN-1:0]  redirect_pc,
    output logic                 imem_req,
    output logic [ADDR_LEN-1:0]  imem_addr,
    input  logic [INSTR_LEN-1:0] imem_inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_LEN-1:0] out_inst,
    output logic [ADDR_LEN-1:0]  out_pc_plus_4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_LEN-1:0] fetch_pc;
    logic [ADDR_LEN-1:0] req_pc;
    logic                inflight;
    logic [CW-1:0]       count;
    logic [CW:0]         occ;
    logic                resp;
    logic                push;
    logic                fifo_pop;
    logic                fifo_valid;
    fetch_entry_t        head;
    fetch_entry_t        push_entry;

    // Occupancy credit: a same-cycle pop is deliberately not counted
    assign occ        = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req   = !rst && !redirect_valid && (occ < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc;

    assign resp       = inflight && !redirect_valid;
    assign push_entry = '{inst: imem_inst, pc_plus_4: req_pc + PC_INC};
    assign fifo_valid = (count != '0) && !redirect_valid;
    assign fifo_pop   = fifo_valid && out_ready;

`ifdef INST_PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass        = resp && (count == '0);
    assign push          = resp && !(bypass && out_ready);
    assign out_valid     = fifo_valid || bypass;
    assign out_inst      = bypass ? push_entry.inst
                         : (count != '0) ? head.inst : '0;
    assign out_pc_plus_4 = bypass ? push_entry.pc_plus_4
                         : (count != '0) ? head.pc_plus_4 : '0;
`else
    assign push          = resp;
    assign out_valid     = fifo_valid;
    assign out_inst      = (count != '0) ? head.inst : '0;
    assign out_pc_plus_4 = (count != '0) ? head.pc_plus_4 : '0;
`endif

    // Fetch PC / in-flight tracking; redirect restarts fetch next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (imem_req) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_INC;
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .clear (redirect_valid),
        .din   (push_entry),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer (DEPTH=4, RESET_PC=0).
// Memory model returns addr ^ 32'hA5A5_0000 one cycle after the request.
module tb_inst_prefetch_buffer;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef INST_PREFETCH_BYPASS_EN
    localparam int LAT  = 1;
    localparam int RLAT = 2;
`else
    localparam int LAT  = 2;
    localparam int RLAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc_plus_4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    inst_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc_plus_4  (out_pc_plus_4)
    );

    always #5 clk = ~clk;

    // Registered instruction memory
    always @(posedge clk) imem_inst <= imem_addr ^ KEY;

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", out_inst); end
        n_tests++; if (out_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want 0", out_pc_plus_4); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        logic        ev;
        exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i * 4));
        do_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        for (int c = 1; c <= 20 && exp_q.size() != 0; c++) begin
            @(negedge clk); #1;
            if (c <= 9) begin
                ev = (c >= LAT);
                n_tests++;
                if (out_valid !== ev) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid, ev); end
            end
            if (out_valid && out_ready) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (out_pc_plus_4 !== exp || out_inst !== ((exp - 32'd4) ^ KEY)) begin
                    n_fail++; $display("FAIL stream_data: got pc4=%h inst=%h want pc4=%h inst=%h", out_pc_plus_4, out_inst, exp, (exp - 32'd4) ^ KEY);
                end
            end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_timeout: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int          nreq;
        logic        seen;
        nreq = 0;
        seen = 1'b0;
        addr_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) addr_q.push_back(32'(i * 4));
        do_reset();
        rst = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (imem_req) begin
                nreq++;
                n_tests++;
                if (addr_q.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra_req: got addr %h want no request", imem_addr);
                end else begin
                    exp = addr_q.pop_front();
                    if (imem_addr !== exp) begin n_fail++; $display("FAIL stall_addr: got %h want %h", imem_addr, exp); end
                end
            end
            @(negedge clk); #1;
        end
        n_tests++; if (nreq != 4) begin n_fail++; $display("FAIL stall_nreq: got %0d want 4", nreq); end
        for (int i = 1; i <= 6; i++) exp_q.push_back(32'(i * 4));
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 30 && (exp_q.size() != 0 || !seen); c++) begin
            if (imem_req && !seen) begin
                seen = 1'b1;
                n_tests++;
                if (imem_addr !== 32'd16) begin n_fail++; $display("FAIL stall_resume: got %h want 00000010", imem_addr); end
            end
            if (out_valid && out_ready) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (out_pc_plus_4 !== exp || out_inst !== ((exp - 32'd4) ^ KEY)) begin
                    n_fail++; $display("FAIL stall_data: got pc4=%h inst=%h want pc4=%h", out_pc_plus_4, out_inst, exp);
                end
            end
            @(negedge clk); #1;
        end
        n_tests++; if (exp_q.size() != 0 || !seen) begin n_fail++; $display("FAIL stall_timeout: %0d left seen=%b want 0 seen=1", exp_q.size(), seen); end
    endtask

    task automatic test_redirect();
        logic [31:0] exp;
        logic        first_valid;
        first_valid = 1'b0;
        exp_q.delete();
        do_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        out_ready = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", out_valid); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", imem_req); end
        exp_q.push_back(32'h44); exp_q.push_back(32'h48); exp_q.push_back(32'h4C);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        for (int c = 1; c < 20 && exp_q.size() != 0; c++) begin
            if (c == 1) begin
                n_tests++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_first_req: got req=%b addr=%h want 1 00000040", imem_req, imem_addr); end
            end
            if (out_valid && !first_valid) begin
                first_valid = 1'b1;
                n_tests++;
                if (c != RLAT) begin n_fail++; $display("FAIL redir_latency: got %0d want %0d", c, RLAT); end
            end
            if (out_valid && out_ready) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (out_pc_plus_4 !== exp || out_inst !== ((exp - 32'd4) ^ KEY)) begin
                    n_fail++; $display("FAIL redir_data: got pc4=%h inst=%h want pc4=%h", out_pc_plus_4, out_inst, exp);
                end
            end
            @(negedge clk); #1;
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_timeout: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        exp_q.delete();
        addr_q.delete();
        do_reset();
        out_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        for (int c = 0; c < 20 && (exp_q.size() != 0 || addr_q.size() != 0); c++) begin
            if (imem_req && addr_q.size() != 0) begin
                exp = addr_q.pop_front();
                n_tests++;
                if (imem_addr !== exp) begin n_fail++; $display("FAIL wrap_addr: got %h want %h", imem_addr, exp); end
            end
            if (out_valid && out_ready) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (out_pc_plus_4 !== exp || out_inst !== ((exp - 32'd4) ^ KEY)) begin
                    n_fail++; $display("FAIL wrap_data: got pc4=%h inst=%h want pc4=%h inst=%h", out_pc_plus_4, out_inst, exp, (exp - 32'd4) ^ KEY);
                end
            end
            @(negedge clk); #1;
        end
        n_tests++; if (exp_q.size() != 0 || addr_q.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: %0d/%0d left want 0", exp_q.size(), addr_q.size()); end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        exp_q.delete();
        do_reset();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL full_state: got valid=%b req=%b want 1 0", out_valid, imem_req); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_req: got %b want 0", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_addr: got %h want 0", imem_addr); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        n_tests++; if (out_inst !== 32'h0 || out_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL arst_data: got inst=%h pc4=%h want 0 0", out_inst, out_pc_plus_4); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL arst_restart: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (out_valid && out_ready) begin
                exp = exp_q.pop_front();
                n_tests++;
                if (out_pc_plus_4 !== exp || out_inst !== ((exp - 32'd4) ^ KEY)) begin
                    n_fail++; $display("FAIL arst_data_after: got pc4=%h inst=%h want pc4=%h", out_pc_plus_4, out_inst, exp);
                end
            end
            @(negedge clk); #1;
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL arst_timeout: %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
